// File: rtl/uart_rx_word_assembler_if.sv
// Output bundle of the UART word assembler.
// master drives words and strobes, slave consumes them.
interface uart_rx_word_assembler_if;
    logic [15:0] Data_out;
    logic        Valid_num;
    logic        Frame_done;
    logic        Frame_err;
    logic [8:0]  Word_count;

    modport master (
        output Data_out,
        output Valid_num,
        output Frame_done,
        output Frame_err,
        output Word_count
    );

    modport slave (
        input Data_out,
        input Valid_num,
        input Frame_done,
        input Frame_err,
        input Word_count
    );
endinterface

// File: rtl/uart_rx_word_assembler.sv
// Oversampling 8N1 UART receiver that pairs bytes low-first
// into 16-bit words and counts them into fixed-size frames.
module uart_rx_word_assembler #(
    parameter int CLKS_PER_BIT   = 104,
    parameter int NUM_WORDS      = 512,
    parameter int TIMEOUT_CYCLES = 12500
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic i_Rx_Serial,
    uart_rx_word_assembler_if.master rx_bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]    WLAST = 9'(NUM_WORDS - 1);

    localparam int I_IDLE    = 0;
    localparam int I_START   = 1;
    localparam int I_DATA    = 2;
    localparam int I_STOP    = 3;
    localparam int I_CLEANUP = 4;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_START   = 5'b00010,
        S_DATA    = 5'b00100,
        S_STOP    = 5'b01000,
        S_CLEANUP = 5'b10000
    } state_t;

    logic rx_meta;
    logic rx_s;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] clk_cnt_nx;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_nx;
    logic [7:0]    shift;
    logic [7:0]    shift_nx;
    logic          stop_ok;
    logic          stop_ok_nx;
    logic          ferr_nx;
    logic          ferr_q;

    logic          phase_high;
    logic [7:0]    low_byte;
    logic [TW-1:0] to_cnt;
    logic [15:0]   data_q;
    logic          valid_q;
    logic          done_q;
    logic [8:0]    wcnt_q;

    logic byte_evt;
    logic drop_evt;
    logic idle_wait;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            stop_ok <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            clk_cnt <= clk_cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            stop_ok <= stop_ok_nx;
            ferr_q  <= ferr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clk_cnt_nx = clk_cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        stop_ok_nx = stop_ok;
        ferr_nx    = 1'b0;
        unique case (1'b1)
            state[I_IDLE]: begin
                if (!rx_s) begin
                    state_nx   = S_START;
                    clk_cnt_nx = '0;
                end
            end
            state[I_START]: begin
                if (clk_cnt == HALF) begin
                    clk_cnt_nx = '0;
                    bit_idx_nx = '0;
                    state_nx   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_nx = clk_cnt + 1'b1;
                end
            end
            state[I_DATA]: begin
                if (clk_cnt == LAST) begin
                    clk_cnt_nx        = '0;
                    shift_nx[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_nx = S_STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 1'b1;
                    end
                end else begin
                    clk_cnt_nx = clk_cnt + 1'b1;
                end
            end
            state[I_STOP]: begin
                if (clk_cnt == LAST) begin
                    clk_cnt_nx = '0;
                    stop_ok_nx = rx_s;
                    ferr_nx    = !rx_s;
                    state_nx   = S_CLEANUP;
                end else begin
                    clk_cnt_nx = clk_cnt + 1'b1;
                end
            end
            state[I_CLEANUP]: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign byte_evt  = state[I_CLEANUP] && stop_ok;
    assign drop_evt  = state[I_CLEANUP] && !stop_ok;
    assign idle_wait = phase_high && state[I_IDLE];

    // Timeout only ages while the line is idle; a byte in flight freezes it.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            phase_high <= 1'b0;
            low_byte   <= '0;
            to_cnt     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (byte_evt && !phase_high) begin
                low_byte   <= shift;
                phase_high <= 1'b1;
                to_cnt     <= '0;
            end else if (byte_evt) begin
                data_q     <= {shift, low_byte};
                valid_q    <= 1'b1;
                phase_high <= 1'b0;
                if (wcnt_q == WLAST) begin
                    wcnt_q <= '0;
                    done_q <= 1'b1;
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
            end else if (drop_evt) begin
                phase_high <= 1'b0;
            end else if (idle_wait) begin
                if (to_cnt == TLAST) begin
                    phase_high <= 1'b0;
                    to_cnt     <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    assign rx_bus.Data_out   = data_q;
    assign rx_bus.Valid_num  = valid_q;
    assign rx_bus.Frame_done = done_q;
    assign rx_bus.Frame_err  = ferr_q;
    assign rx_bus.Word_count = wcnt_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Random and directed serial traffic against a byte-level
// model of word pairing, timeouts, framing errors and frames.
module tb_uart_rx_word_assembler;

    localparam int CPB = 104;
    localparam int NW  = 4;
    localparam int TO  = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic line  = 1'b1;

    always #5 clk = ~clk;

    uart_rx_word_assembler_if bus ();

    uart_rx_word_assembler #(
        .CLKS_PER_BIT   (CPB),
        .NUM_WORDS      (NW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .i_Rx_Serial (line),
        .rx_bus      (bus)
    );

    typedef struct {
        logic [15:0] data;
        logic [8:0]  cnt;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;

    int n_chk  = 0;
    int n_fail = 0;
    int err_pend = 0;
    bit chk_en = 0;

    logic [15:0] m_last = '0;
    logic [8:0]  m_wcnt = '0;
    bit          m_high = 0;
    logic [7:0]  m_low  = '0;
    int          m_cnt  = 0;
    int          gap    = 0;

    int          n_valid = 0;
    int          n_done  = 0;
    int          n_ferr  = 0;
    int          done_at = 0;
    logic [15:0] dut_word = '0;

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.Valid_num) begin
                n_valid++;
                dut_word = bus.Data_out;
                check("valid_with_err", 32'(bus.Frame_err), 0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got %0h expected none",
                             bus.Data_out);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("word_data", 32'(bus.Data_out),
                          32'(e_cur.data));
                    check("word_count_at_valid",
                          32'(bus.Word_count), 32'(e_cur.cnt));
                    check("frame_done_at_valid",
                          32'(bus.Frame_done), 32'(e_cur.done));
                    m_last = e_cur.data;
                    m_wcnt = e_cur.cnt;
                end
                if (bus.Frame_done) begin
                    n_done++;
                    done_at = n_valid;
                end
            end else begin
                check("data_stable", 32'(bus.Data_out), 32'(m_last));
                check("word_count", 32'(bus.Word_count), 32'(m_wcnt));
                check("done_without_valid", 32'(bus.Frame_done), 0);
            end
            if (bus.Frame_err) begin
                n_ferr++;
                n_chk++;
                if (err_pend == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame_err: got 1 expected 0");
                end else begin
                    err_pend--;
                end
            end
        end
    end

    task automatic model_reset();
        m_high = 0;
        m_cnt  = 0;
        m_last = '0;
        m_wcnt = '0;
        exp_q.delete();
        err_pend = 0;
        gap = 0;
    endtask

    task automatic model_byte(logic [7:0] b, bit good);
        exp_t e;
        bit   d;
        if (m_high && gap >= TO) m_high = 0;
        if (!good) begin
            err_pend++;
            m_high = 0;
        end else if (!m_high) begin
            m_low  = b;
            m_high = 1;
        end else begin
            d = (m_cnt == NW - 1);
            m_cnt = d ? 0 : m_cnt + 1;
            e.data = {b, m_low};
            e.cnt  = 9'(m_cnt);
            e.done = d;
            exp_q.push_back(e);
            m_high = 0;
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
        gap += n;
    endtask

    task automatic drive_bit(logic v);
        line = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(logic [7:0] b, bit good);
        model_byte(b, good);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(good);
        line = 1'b1;
        gap = 0;
        check("strobe_in_time", 32'(exp_q.size()), 0);
        check("err_in_time", 32'(err_pend), 0);
        if (!good) idle(2 * CPB);
    endtask

    initial begin
        int bv;
        int bf;
        int bd;
        logic [7:0] rb;
        logic [7:0] hb;

        rst_n = 1'b0;
        line  = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data", 32'(bus.Data_out), 0);
        check("rst_valid", 32'(bus.Valid_num), 0);
        check("rst_done", 32'(bus.Frame_done), 0);
        check("rst_err", 32'(bus.Frame_err), 0);
        check("rst_count", 32'(bus.Word_count), 0);
        rst_n = 1'b1;
        model_reset();
        chk_en = 1;
        idle(20);

        bv = n_valid;
        bf = n_ferr;
        send_byte(8'h34, 1);
        send_byte(8'h12, 1);
        idle(10);
        check("t1_word", 32'(dut_word), 32'h1234);
        check("t1_count", 32'(bus.Word_count), 1);
        check("t1_nvalid", 32'(n_valid - bv), 1);
        check("t1_nerr", 32'(n_ferr - bf), 0);

        bv = n_valid;
        send_byte(8'hAA, 1);
        idle(TO + 10);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        idle(10);
        check("t2_nvalid", 32'(n_valid - bv), 1);
        check("t2_word", 32'(dut_word), 32'h0201);

        bv = n_valid;
        idle(50);
        line = 1'b0;
        repeat (40) @(negedge clk);
        line = 1'b1;
        idle(200);
        check("glitch_nvalid", 32'(n_valid - bv), 0);
        send_byte(8'h5A, 1);
        send_byte(8'hC3, 1);
        idle(10);
        check("glitch_word", 32'(dut_word), 32'hC35A);

        bv = n_valid;
        bf = n_ferr;
        send_byte(8'h55, 1);
        send_byte(8'h77, 0);
        check("ferr_count", 32'(n_ferr - bf), 1);
        check("ferr_nvalid", 32'(n_valid - bv), 0);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        idle(10);
        check("ferr_word", 32'(dut_word), 32'h2211);
        check("ferr_nvalid2", 32'(n_valid - bv), 1);
        check("frame_wrapped", 32'(bus.Word_count), 0);

        bv = n_valid;
        bd = n_done;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1);
        idle(10);
        check("frame_nvalid", 32'(n_valid - bv), 4);
        check("frame_ndone", 32'(n_done - bd), 1);
        check("frame_done_4th", 32'(done_at - bv), 4);
        check("frame_count0", 32'(bus.Word_count), 0);
        send_byte(8'hE1, 1);
        send_byte(8'hD2, 1);
        idle(10);
        check("frame_next_count", 32'(bus.Word_count), 1);
        check("frame_next_word", 32'(dut_word), 32'hD2E1);

        for (int k = 0; k < 20; k++) begin
            rb = 8'($urandom);
            send_byte(rb, $urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0)
                idle(TO + 10 + $urandom_range(0, 300));
            else
                idle($urandom_range(0, 300));
        end

        idle(TO + 50);
        send_byte(8'h9C, 1);
        hb = 8'hF0;
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(hb[i]);
        line = hb[5];
        repeat (CPB / 2) @(negedge clk);
        chk_en = 0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("mid_rst_data", 32'(bus.Data_out), 0);
        check("mid_rst_valid", 32'(bus.Valid_num), 0);
        check("mid_rst_done", 32'(bus.Frame_done), 0);
        check("mid_rst_err", 32'(bus.Frame_err), 0);
        check("mid_rst_count", 32'(bus.Word_count), 0);
        chk_en = 1;
        repeat (CPB / 2 - 1) @(negedge clk);
        drive_bit(hb[6]);
        drive_bit(hb[7]);
        drive_bit(1'b1);
        line = 1'b1;
        gap = 0;
        idle(50);
        bv = n_valid;
        send_byte(8'h78, 1);
        send_byte(8'h56, 1);
        idle(10);
        check("post_rst_word", 32'(dut_word), 32'h5678);
        check("post_rst_count", 32'(bus.Word_count), 1);
        check("post_rst_nvalid", 32'(n_valid - bv), 1);

        idle(20);
        check("exp_q_empty", 32'(exp_q.size()), 0);
        check("err_pend_empty", 32'(err_pend), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
